serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial N-bit adder/subtractor: accepts two operands plus a mode bit, computes A+B or A-B
//  one bit per cycle LSB-first through a single 1-bit full-adder cell, returns result + carry/borrow.
//  Sits beside the combinational adder path as the low-area arithmetic unit behind a valid/ready handshake.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
//  CNT_W   4   counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  CLK        in   1      rising-edge clock
//  RST        in   1      synchronous, active-high reset
//  IN_VALID   in   1      operands + mode valid this cycle
//  IN_READY   out  1      block can accept operands (high only in IDLE)
//  IN_A       in   WIDTH  operand A (unsigned)
//  IN_B       in   WIDTH  operand B (unsigned)
//  IN_SUB     in   1      0: A+B, 1: A-B
//  OUT_VALID  out  1      result valid; held until accepted
//  OUT_READY  in   1      downstream accepts result
//  OUT_F      out  WIDTH  sum/difference, modulo 2**WIDTH
//  OUT_C      out  1      add: carry-out; sub: borrow (1 when A<B)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset (RST=1 at edge): state=IDLE, IN_READY=1, OUT_VALID=0, OUT_F=0, OUT_C=0, counter=0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: IN_READY=1. On IN_VALID&IN_READY: latch A, B^{WIDTH{IN_SUB}}, SUB; carry reg=IN_SUB; cnt=0; ->RUN.
//   RUN: each cycle cell sums a[0], b[0], carry; result shifts in at MSB; a,b shift right; carry updates;
//        cnt++. After WIDTH RUN cycles (cnt==WIDTH-1 at edge) -> DONE.
//   DONE: OUT_VALID=1, OUT_F=result, OUT_C = SUB ? ~carry : carry. On OUT_READY -> IDLE.
//  Latency: operand accept edge to OUT_VALID high = WIDTH+1 cycles; OUT_VALID seen at cycle WIDTH+1.
//  Throughput: one operation per WIDTH+2 cycles minimum (no overlap; IN_READY=0 in RUN/DONE).
//  OUT_F/OUT_C stable for entire DONE; only change on next completion or reset.
//  IN_VALID in RUN/DONE ignored; inputs not sampled. OUT_READY outside DONE ignored.
//  OUT_READY already high on entry to DONE: OUT_VALID high exactly one cycle, back to IDLE next edge.
//  Wrap-around: results taken modulo 2**WIDTH; overflow only reported via OUT_C.
//  Reset mid-RUN or mid-DONE: operation discarded, all outputs to reset values next edge, no result emitted.
//  RST has priority over every handshake event in the same cycle.
// STRUCTURE
//  Shared package (arith_pkg): state enum {IDLE, RUN, DONE} as 2-bit localparams; MODE_ADD=0, MODE_SUB=1.
//  Sub-module: fa_cell (1-bit full adder: a, b, cin -> s, cout), one instance, purely combinational.
//  Top holds FSM, shift registers (a, b, result), carry flop, counter, output registers.
// TESTING
//  T1 WIDTH=8: A=0x05,B=0x03,SUB=0 -> OUT_F=0x08,OUT_C=0, OUT_VALID exactly 9 cycles after accept.
//  T2 A=0xFF,B=0x01,SUB=0 -> OUT_F=0x00,OUT_C=1 (wrap-around carry).
//  T3 A=0x05,B=0x07,SUB=1 -> OUT_F=0xFE,OUT_C=1 (borrow); A=0x07,B=0x05,SUB=1 -> 0x02,C=0.
//  T4 OUT_READY=0 for 5 cycles in DONE -> OUT_VALID, OUT_F held; IN_VALID pulses ignored; accept -> IDLE.
//  T5 RST asserted 3 cycles into RUN -> next edge IN_READY=1, OUT_VALID=0, OUT_F=0; no stale result later.
//  T6 Random 1000 ops both modes, random OUT_READY stalls -> compare against (A±B) mod 256 and carry/borrow.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding and mode constants for the serial adder/subtractor
package arith_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit combinational full adder (a, b, cin -> s, cout)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial A+B / A-B, one bit per cycle LSB-first, valid/ready on both sides
//   in:  CLK, RST (sync, active-high), IN_VALID, IN_A, IN_B, IN_SUB, OUT_READY
//   out: IN_READY (high in IDLE), OUT_VALID (high in DONE), OUT_F (result mod 2**WIDTH),
//        OUT_C (carry-out on add, borrow on sub)
module serial_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic             IN_SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_F,
    output logic             OUT_C
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d, c_q, c_d;
    logic             s, cout;

    fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .s(s), .cout(cout));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        c_d     = c_q;
        if (state_q == IDLE && IN_VALID) begin
            // subtraction is A + ~B + 1: invert B and seed the carry with 1
            a_d     = IN_A;
            b_d     = IN_B ^ {WIDTH{IN_SUB}};
            sub_d   = IN_SUB;
            carry_d = IN_SUB;
            res_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {s, res_q[WIDTH-1:1]};
            carry_d = cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                // publish on the last bit so OUT_F/OUT_C hold steady through DONE
                f_d     = {s, res_q[WIDTH-1:1]};
                c_d     = (sub_q == MODE_SUB) ? ~cout : cout;
                state_d = DONE;
            end
        end else if (state_q == DONE && OUT_READY) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= MODE_ADD;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign OUT_F     = f_q;
    assign OUT_C     = c_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and randomized checks of serial_add_sub against an arithmetic model
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_f;
    logic       out_c;
    int         checks = 0;
    int         failures = 0;

    serial_add_sub #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_A(in_a), .IN_B(in_b), .IN_SUB(in_sub), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_F(out_f), .OUT_C(out_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation: accept, wait for result, optionally stall in DONE, then retire.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input int stall, input bit noise);
        logic [8:0] full;
        logic [7:0] exp_f;
        logic       exp_c;
        int         n;
        full  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        exp_f = full[7:0];
        exp_c = sub ? (a < b) : full[8];
        check("ready_before_op", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = (stall == 0);
        tick();
        n = 1;
        in_valid = noise ? 1'(($urandom & 1)) : 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_sub   = 1'($urandom);
        check("ready_low_in_run", {31'd0, in_ready}, 32'd0);
        while (!out_valid && n < 30) begin
            tick();
            n++;
            if (noise) in_valid = 1'($urandom);
        end
        check("latency", n, 9);
        check("out_f", {24'd0, out_f}, {24'd0, exp_f});
        check("out_c", {31'd0, out_c}, {31'd0, exp_c});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_f", {24'd0, out_f}, {24'd0, exp_f});
            check("stall_c", {31'd0, out_c}, {31'd0, exp_c});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("retire_valid", {31'd0, out_valid}, 32'd0);
        check("retire_ready", {31'd0, in_ready}, 32'd1);
        check("retire_f_held", {24'd0, out_f}, {24'd0, exp_f});
        out_ready = 1'(($urandom & 1));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_f", {24'd0, out_f}, 32'd0);
        check("rst_c", {31'd0, out_c}, 32'd0);

        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 0, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 5, 1'b1);

        // reset three cycles into RUN discards the operation
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h20;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrun_ready", {31'd0, in_ready}, 32'd1);
        check("rrun_valid", {31'd0, out_valid}, 32'd0);
        check("rrun_f", {24'd0, out_f}, 32'd0);
        check("rrun_c", {31'd0, out_c}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rrun_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // reset while holding a result in DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h80;
        in_b      = 8'h80;
        in_sub    = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rdone_pre_valid", {31'd0, out_valid}, 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("rdone_valid", {31'd0, out_valid}, 32'd0);
        check("rdone_ready", {31'd0, in_ready}, 32'd1);
        check("rdone_f", {24'd0, out_f}, 32'd0);
        check("rdone_c", {31'd0, out_c}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
